// File: rtl/pia_pkg.sv
// rtl/pia_pkg.sv - shared types and constants for the PIA host port
// Purpose: FSM state encoding, PIA register-select codes and control-register
//          flag bit positions used by pia_host_port.
// Ports:   none (package).
package pia_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    ACCESS   = 3'd2,
    DONE     = 3'd3,
    P_SETUP  = 3'd4,
    P_ACCESS = 3'd5
  } pia_state_e;

  localparam logic [1:0] RS_DATA = 2'b00;
  localparam logic [1:0] RS_CTRL = 2'b11;

  localparam int FLAG_HI_BIT = 7;
  localparam int FLAG_LO_BIT = 6;

endpackage

// File: rtl/pia_poll_timer.sv
// rtl/pia_poll_timer.sv - free-running poll interval counter
// Purpose: counts 0..POLL_PERIOD-1 while enabled and flags the wrap cycle;
//          held at zero while disabled.
// Ports:   clk, reset (async, active-high), en (count enable),
//          wrap (high in the cycle whose posedge wraps the counter to 0).
module pia_poll_timer #(
  parameter int POLL_PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic wrap
);

  localparam logic [7:0] LAST = 8'(POLL_PERIOD - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (!en || wrap) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pia_host_port.sv
// rtl/pia_host_port.sv - host-side access sequencer for a PIA register file
// Purpose: turns single-cycle register requests into SETUP/ACCESS/DONE bus
//          cycles, and periodically reads the control register to collect
//          interrupt flags when polling is enabled.
// Ports:   clk, reset (async, active-high)
//          req/req_we/req_sel/req_wdata -> ack/rdata   requester side
//          rs0/rs1/rw/bus_dout, bus_din                PIA bus side
//          poll_en -> irq_flags/irq_event              polling side
module pia_host_port
  import pia_pkg::*;
#(
  parameter int POLL_PERIOD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       req_we,
  input  logic [1:0] req_sel,
  input  logic [7:0] req_wdata,
  output logic       ack,
  output logic [7:0] rdata,
  output logic       rs0,
  output logic       rs1,
  output logic       rw,
  output logic [7:0] bus_dout,
  input  logic [7:0] bus_din,
  input  logic       poll_en,
  output logic [1:0] irq_flags,
  output logic       irq_event
);

  pia_state_e state_q, state_d;
  logic       we_q, we_d;
  logic [1:0] rs_q, rs_d;
  logic       rw_q, rw_d;
  logic [7:0] dout_q, dout_d;
  logic       ack_q, ack_d;
  logic [7:0] rdata_q, rdata_d;
  logic [1:0] flags_q, flags_d;
  logic       irq_ev_q, irq_ev_d;
  logic       pend_q, pend_d;
  logic       wrap;

  pia_poll_timer #(
    .POLL_PERIOD(POLL_PERIOD)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .en   (poll_en),
    .wrap (wrap)
  );

  // Bus outputs are registered on the edge that enters a state, so the
  // values shown here are what the PIA sees during the *next* state.
  // ack is raised on the DONE->IDLE edge, giving the 3-cycle latency.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    dout_d   = dout_q;
    ack_d    = 1'b0;
    rdata_d  = rdata_q;
    flags_d  = flags_q;
    irq_ev_d = 1'b0;
    pend_d   = pend_q;

    case (state_q)
      IDLE: begin
        // User requests take priority; a pending poll simply waits.
        if (req) begin
          state_d = SETUP;
          we_d    = req_we;
          rs_d    = req_sel;
          rw_d    = ~req_we;
          dout_d  = req_we ? req_wdata : 8'h00;
        end else if (pend_q) begin
          state_d = P_SETUP;
          rs_d    = RS_CTRL;
          rw_d    = 1'b1;
          dout_d  = 8'h00;
          pend_d  = 1'b0;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (!we_q) begin
          rdata_d = bus_din;
        end
        state_d = DONE;
      end
      DONE: begin
        ack_d   = 1'b1;
        rs_d    = RS_DATA;
        rw_d    = 1'b1;
        dout_d  = 8'h00;
        state_d = IDLE;
      end
      P_SETUP: begin
        state_d = P_ACCESS;
      end
      P_ACCESS: begin
        flags_d  = {bus_din[FLAG_HI_BIT], bus_din[FLAG_LO_BIT]};
        irq_ev_d = bus_din[FLAG_HI_BIT] | bus_din[FLAG_LO_BIT];
        rs_d     = RS_DATA;
        rw_d     = 1'b1;
        dout_d   = 8'h00;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
        rs_d    = RS_DATA;
        rw_d    = 1'b1;
        dout_d  = 8'h00;
      end
    endcase

    // A fresh wrap outranks the clear from a poll starting on the same edge;
    // disabling polling discards anything outstanding.
    if (wrap) begin
      pend_d = 1'b1;
    end
    if (!poll_en) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      rs_q     <= RS_DATA;
      rw_q     <= 1'b1;
      dout_q   <= 8'h00;
      ack_q    <= 1'b0;
      rdata_q  <= 8'h00;
      flags_q  <= 2'b00;
      irq_ev_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      rs_q     <= rs_d;
      rw_q     <= rw_d;
      dout_q   <= dout_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      flags_q  <= flags_d;
      irq_ev_q <= irq_ev_d;
      pend_q   <= pend_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign rs0       = rs_q[0];
  assign rs1       = rs_q[1];
  assign rw        = rw_q;
  assign bus_dout  = dout_q;
  assign irq_flags = flags_q;
  assign irq_event = irq_ev_q;

endmodule

// File: tb/tb_pia_host_port.sv
// tb/tb_pia_host_port.sv - self-checking bench for pia_host_port
module tb_pia_host_port;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       req_we;
  logic [1:0] req_sel;
  logic [7:0] req_wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       rs0, rs1, rw;
  logic [7:0] bus_dout;
  logic [7:0] bus_din;
  logic       poll_en;
  logic [1:0] irq_flags;
  logic       irq_event;

  int n_cmp = 0;
  int n_bad = 0;

  pia_host_port #(.POLL_PERIOD(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .req_we   (req_we),
    .req_sel  (req_sel),
    .req_wdata(req_wdata),
    .ack      (ack),
    .rdata    (rdata),
    .rs0      (rs0),
    .rs1      (rs1),
    .rw       (rw),
    .bus_dout (bus_dout),
    .bus_din  (bus_din),
    .poll_en  (poll_en),
    .irq_flags(irq_flags),
    .irq_event(irq_event)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rs"}, {30'd0, rs1, rs0}, 32'd0);
    chk({tag, "_rw"}, {31'd0, rw}, 32'd1);
    chk({tag, "_dout"}, {24'd0, bus_dout}, 32'd0);
    chk({tag, "_ack"}, {31'd0, ack}, 32'd0);
  endtask

  typedef struct {
    logic       we;
    logic [1:0] sel;
    logic [7:0] wdata;
    logic [7:0] din;
    logic [1:0] exp_rs;
    logic       exp_rw;
    logic [7:0] exp_dout;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t vec [6];

  initial begin
    int n;
    int first_ack;
    int second_ack;
    int acks;
    bit found;
    bit ack_seen;
    bit drop_next;

    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first_ack;
    int second_ack;
    int acks;
    bit found;
    bit ack_seen;
    bit drop_next;

    //            we  sel    wdata  din    rs     rw    dout   rdata
    vec[0] = '{1'b1, 2'b11, 8'hA5, 8'h00, 2'b11, 1'b0, 8'hA5, 8'h00};
    vec[1] = '{1'b0, 2'b11, 8'h00, 8'hC3, 2'b11, 1'b1, 8'h00, 8'hC3};
    vec[2] = '{1'b1, 2'b01, 8'h3C, 8'h99, 2'b01, 1'b0, 8'h3C, 8'hC3};
    vec[3] = '{1'b0, 2'b10, 8'hEE, 8'h5A, 2'b10, 1'b1, 8'h00, 8'h5A};
    vec[4] = '{1'b0, 2'b00, 8'h11, 8'hFF, 2'b00, 1'b1, 8'h00, 8'hFF};
    vec[5] = '{1'b1, 2'b10, 8'h00, 8'h12, 2'b10, 1'b0, 8'h00, 8'hFF};

    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_sel = 2'b00;
    req_wdata = 8'h00; bus_din = 8'h00; poll_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle_outputs("rst");
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_flags", {30'd0, irq_flags}, 32'd0);
    chk("rst_irq_event", {31'd0, irq_event}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("post_rst");

    // Table-driven single accesses.
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      req_we = vec[i].we; req_sel = vec[i].sel; req_wdata = vec[i].wdata;
      bus_din = vec[i].din; req = 1'b1;
      @(posedge clk); #1 req = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_setup_rs", i), {30'd0, rs1, rs0}, {30'd0, vec[i].exp_rs});
      chk($sformatf("v%0d_setup_rw", i), {31'd0, rw}, {31'd0, vec[i].exp_rw});
      chk($sformatf("v%0d_setup_dout", i), {24'd0, bus_dout}, {24'd0, vec[i].exp_dout});
      chk($sformatf("v%0d_setup_ack", i), {31'd0, ack}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_access_rs", i), {30'd0, rs1, rs0}, {30'd0, vec[i].exp_rs});
      chk($sformatf("v%0d_access_rw", i), {31'd0, rw}, {31'd0, vec[i].exp_rw});
      chk($sformatf("v%0d_access_dout", i), {24'd0, bus_dout}, {24'd0, vec[i].exp_dout});
      @(negedge clk);
      chk($sformatf("v%0d_done_ack", i), {31'd0, ack}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_ack", i), {31'd0, ack}, 32'd1);
      chk($sformatf("v%0d_rdata", i), {24'd0, rdata}, {24'd0, vec[i].exp_rdata});
      chk($sformatf("v%0d_end_rw", i), {31'd0, rw}, 32'd1);
      chk($sformatf("v%0d_end_rs", i), {30'd0, rs1, rs0}, 32'd0);
      chk($sformatf("v%0d_end_dout", i), {24'd0, bus_dout}, 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_ack_drop", i), {31'd0, ack}, 32'd0);
      @(posedge clk); #1;
    end

    // Automatic poll: bus_din=80 -> flags 10, one irq_event pulse, no ack.
    bus_din = 8'h80; poll_en = 1'b1;
    n = 0; found = 1'b0; ack_seen = 1'b0;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge clk);
      if (ack) ack_seen = 1'b1;
      if ({rs1, rs0} == 2'b11) begin
        found = 1'b1;
        n = c;
      end
    end
    chk("poll_start_cycle", n, 32'd18);
    chk("poll_setup_rw", {31'd0, rw}, 32'd1);
    @(negedge clk);
    chk("poll_access_rs", {30'd0, rs1, rs0}, 32'd3);
    chk("poll_access_ev", {31'd0, irq_event}, 32'd0);
    if (ack) ack_seen = 1'b1;
    @(negedge clk);
    chk("poll_flags", {30'd0, irq_flags}, 32'd2);
    chk("poll_event", {31'd0, irq_event}, 32'd1);
    chk("poll_end_rs", {30'd0, rs1, rs0}, 32'd0);
    if (ack) ack_seen = 1'b1;
    @(negedge clk);
    chk("poll_event_drop", {31'd0, irq_event}, 32'd0);
    chk("poll_no_ack", {31'd0, ack_seen}, 32'd0);
    chk("poll_rdata_kept", {24'd0, rdata}, 32'hFF);
    @(posedge clk); #1 poll_en = 1'b0;

    // Collision: req arrives in the same IDLE cycle the poll becomes pending.
    @(posedge clk); #1;
    bus_din = 8'h41; req_we = 1'b0; req_sel = 2'b01; poll_en = 1'b1;
    repeat (16) @(posedge clk);
    #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    chk("col_user_rs", {30'd0, rs1, rs0}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("col_ack", {31'd0, ack}, 32'd1);
    chk("col_rdata", {24'd0, rdata}, 32'h41);
    @(negedge clk);
    chk("col_poll_rs", {30'd0, rs1, rs0}, 32'd3);
    chk("col_poll_rw", {31'd0, rw}, 32'd1);
    chk("col_poll_ack", {31'd0, ack}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("col_flags", {30'd0, irq_flags}, 32'd1);
    chk("col_event", {31'd0, irq_event}, 32'd1);
    chk("col_rdata_kept", {24'd0, rdata}, 32'h41);
    @(posedge clk); #1 poll_en = 1'b0;

    // Reset asserted during ACCESS of a write, requester held high.
    @(posedge clk); #1;
    req_we = 1'b1; req_sel = 2'b11; req_wdata = 8'hA5; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstacc_setup_rw", {31'd0, rw}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk_idle_outputs("rstacc");
    chk("rstacc_rdata", {24'd0, rdata}, 32'd0);
    chk("rstacc_flags", {30'd0, irq_flags}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 req = 1'b0;
    n = 0;
    for (int c = 1; c <= 10 && n == 0; c++) begin
      @(negedge clk);
      if (c == 1) chk("rstacc_retry_dout", {24'd0, bus_dout}, 32'hA5);
      if (ack) n = c;
    end
    chk("rstacc_ack_latency", n, 32'd4);

    // Back-to-back: req held for two reads.
    @(posedge clk); #1;
    req_we = 1'b0; req_sel = 2'b00; bus_din = 8'h77; req = 1'b1;
    first_ack = 0; second_ack = 0; acks = 0; drop_next = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      #1;
      if (drop_next) begin
        req = 1'b0;
        drop_next = 1'b0;
      end
      @(negedge clk);
      if (ack) begin
        acks++;
        if (acks == 1) begin
          first_ack = c;
          drop_next = 1'b1;
          chk("b2b_rw_between", {31'd0, rw}, 32'd1);
          chk("b2b_rdata1", {24'd0, rdata}, 32'h77);
        end else if (acks == 2) begin
          second_ack = c;
        end
      end
    end
    chk("b2b_first_ack", first_ack, 32'd4);
    chk("b2b_gap", second_ack - first_ack, 32'd4);
    chk("b2b_ack_count", acks, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pia_host_port.md
PIA_HOST_PORT -- requirements
Module: pia_host_port

Interface
REQ-001 SHALL have parameter POLL_PERIOD, default 16: clock cycles between automatic control-register polls, legal range 4..255.
REQ-002 SHALL have port clk  input  1: single clock; all state changes on posedge clk.
REQ-003 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-004 SHALL have port req  input  1: requester asks for one register access.
REQ-005 SHALL have port req_we  input  1: 1 = write, 0 = read.
REQ-006 SHALL have port req_sel  input  2: register select, bit0 -> rs0, bit1 -> rs1.
REQ-007 SHALL have port req_wdata  input  8: write data.
REQ-008 SHALL have port ack  output  1: one-cycle pulse, access complete.
REQ-009 SHALL have port rdata  output  8: read data, valid from the ack cycle until the next ack.
REQ-010 SHALL have ports rs0, rs1  output  1 each: PIA register select.
REQ-011 SHALL have port rw  output  1: PIA read/write, 1 = read.
REQ-012 SHALL have port bus_dout  output  8: data driven to the PIA datain.
REQ-013 SHALL have port bus_din  input  8: PIA dataout, tri-state resolved externally.
REQ-014 SHALL have port poll_en  input  1: enable automatic polling.
REQ-015 SHALL have port irq_flags  output  2: last polled control bits {7,6}.
REQ-016 SHALL have port irq_event  output  1: one-cycle pulse when a poll finds bit 7 or bit 6 set.

Function
REQ-017 SHALL implement an FSM with states IDLE, SETUP, ACCESS, DONE, P_SETUP, P_ACCESS.
REQ-018 In IDLE with req=1, SHALL latch req_we, req_sel and req_wdata and go to SETUP; req is sampled only in IDLE.
REQ-019 In SETUP, SHALL drive rs0/rs1 from the latched select, rw = ~we, and bus_dout = wdata on writes (00 on reads).
REQ-020 SHALL hold rs/rw/bus_dout stable through ACCESS; on reads, rdata SHALL capture bus_din at the end of ACCESS.
REQ-021 In DONE, SHALL pulse ack for exactly one cycle, then return to IDLE with rw=1, rs=00, bus_dout=00.
REQ-022 Latency: ack SHALL assert exactly 3 cycles after the posedge that accepted req.
REQ-023 Deasserting req after acceptance SHALL NOT abort the access; a req still high in the cycle after DONE SHALL start a new access.
REQ-024 A poll timer SHALL count 0..POLL_PERIOD-1 while poll_en=1, wrap to 0, and be cleared and held at 0 while poll_en=0.
REQ-025 On wrap, SHALL set poll_pending; poll_pending SHALL clear when a poll starts or when poll_en goes to 0.
REQ-026 In IDLE with both req and poll_pending set, the user request SHALL win and the poll SHALL stay pending.
REQ-027 In IDLE with poll_pending=1 and req=0, SHALL enter P_SETUP (rs=11, rw=1) and then P_ACCESS.
REQ-028 At the end of P_ACCESS, SHALL load irq_flags from bus_din[7:6] and return to IDLE; no ack SHALL be generated and rdata SHALL be unchanged.
REQ-029 SHALL pulse irq_event in the cycle after P_ACCESS if the captured bits are nonzero.
REQ-030 A req arriving during a poll SHALL wait; it SHALL be accepted in the first IDLE cycle after the poll.

Reset
REQ-031 Reset SHALL force IDLE, rw=1, rs0=rs1=0, bus_dout=00, ack=0, rdata=00, irq_flags=00, irq_event=0, timer=0, poll_pending=0.
REQ-032 Reset during any state SHALL abandon the access with no ack, and the held requester SHALL be re-accepted after release.

Structure
REQ-033 Package pia_pkg SHALL hold the state enum and the constants RS_DATA=2'b00, RS_CTRL=2'b11 and the flag bit indices 7/6.
REQ-034 SHALL instantiate one sub-module, pia_poll_timer, containing the counter and the wrap pulse; the FSM and datapath SHALL remain in the top module.

Verification
REQ-035 Write: req_we=1, sel=11, wdata=A5 -> in SETUP/ACCESS rw=0, rs=11, bus_dout=A5; ack 3 cycles later.
REQ-036 Read: sel=11, bus_din=C3 -> rw=1 throughout, rdata=C3 at ack, ack=1 for exactly one cycle.
REQ-037 Poll: poll_en=1, POLL_PERIOD=16, bus_din=80 -> P_SETUP ~16 cycles after enable, irq_flags=10, irq_event one pulse, no ack.
REQ-038 Collision: req and poll_pending in the same IDLE cycle -> user access completes first, poll follows immediately after, both results correct.
REQ-039 Reset asserted in ACCESS of a write -> outputs at reset values asynchronously, no ack; with req still high, ack follows 3 cycles after release.
REQ-040 Back-to-back: req held high for two accesses -> two acks separated by 4 cycles, rw returns to 1 between accesses.
